// File: rtl/rca_operand_stager_pkg.sv
// Shared definitions for the ripple-carry operand stager: default width,
// FSM state encoding and settle-counter width.
package rca_operand_stager_pkg;

  localparam int WIDTH_DEF = 27;
  localparam int CNT_W     = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/rca_operand_stager_if.sv
// Operand/result handshake bundle for rca_operand_stager. o_check_err exists
// only when RCA_STAGER_SELF_CHECK_EN is defined.
interface rca_operand_stager_if
  import rca_operand_stager_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_add_term1;
  logic [WIDTH-1:0] i_add_term2;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH:0]   o_result;
  logic             o_busy;
`ifdef RCA_STAGER_SELF_CHECK_EN
  logic             o_check_err;
`endif

  modport slave (
    input  i_valid, i_add_term1, i_add_term2, i_ready,
    output o_ready, o_valid, o_result, o_busy
`ifdef RCA_STAGER_SELF_CHECK_EN
    , output o_check_err
`endif
  );

  modport master (
    output i_valid, i_add_term1, i_add_term2, i_ready,
    input  o_ready, o_valid, o_result, o_busy
`ifdef RCA_STAGER_SELF_CHECK_EN
    , input o_check_err
`endif
  );
endinterface

// File: rtl/rca_operand_stager_adder.sv
// Purely combinational ripple-carry adder built from a chain of full-adder
// cells; the carry out becomes the top bit of the sum.
module ripple_carry_adder_27bit #(
  parameter int WIDTH = 27
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH:0]   sum_o
);

  logic carry;

  // NOTE: every variable assigned in always_comb gets a value before any
  // branch or loop, otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    carry = 1'b0;
    sum_o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
      carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
    end
    sum_o[WIDTH] = carry;
  end

endmodule

// File: rtl/rca_operand_stager.sv
// Holds an operand pair stable across the adder ripple window, then presents
// the registered sum downstream. Optional self-check: RCA_STAGER_SELF_CHECK_EN.
module rca_operand_stager
  import rca_operand_stager_pkg::*;
#(
  parameter int WIDTH         = WIDTH_DEF,
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rca_operand_stager_if.slave  bus
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_settle_range
    $error("rca_operand_stager: SETTLE_CYCLES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_e           state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic [WIDTH-1:0] a_q,      a_d;
  logic [WIDTH-1:0] b_q,      b_d;
  logic [WIDTH:0]   result_q, result_d;
  logic             valid_q,  valid_d;
  logic             ready;
  logic             capture;
  logic [WIDTH:0]   sum_w;

  ripple_carry_adder_27bit #(.WIDTH(WIDTH)) u_adder (
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (sum_w)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    valid_d  = valid_q;
    ready    = 1'b0;
    capture  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
      end
      ST_SETTLE: begin
        if (cnt_q == '0) begin
          capture  = 1'b1;
          result_d = sum_w;
          valid_d  = 1'b1;
          state_d  = ST_HOLD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        // A new pair may only enter on the same edge the result leaves.
        ready = bus.i_ready;
        if (bus.i_ready) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (ready && bus.i_valid) begin
      a_d     = bus.i_add_term1;
      b_d     = bus.i_add_term2;
      cnt_d   = CNT_LOAD;
      state_d = ST_SETTLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.o_ready  = ready;
  assign bus.o_valid  = valid_q;
  assign bus.o_result = result_q;
  assign bus.o_busy   = (state_q != ST_IDLE);

`ifdef RCA_STAGER_SELF_CHECK_EN
  logic           err_q, err_d;
  logic [WIDTH:0] ref_sum;

  always_comb begin
    ref_sum = (WIDTH+1)'(a_q) + (WIDTH+1)'(b_q);
    err_d   = err_q | (capture && (sum_w != ref_sum));
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign bus.o_check_err = err_q;
`else
  logic unused_capture;
  assign unused_capture = capture;
`endif

endmodule

// File: tb/tb_rca_operand_stager.sv
// Randomized self-checking bench for rca_operand_stager against a plain
// arithmetic model of the staged adder.
module tb_rca_operand_stager;

  localparam int W  = 27;
  localparam int SC = 2;
  localparam logic [W-1:0] MASK = {W{1'b1}};

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  rca_operand_stager_if #(.WIDTH(W)) bus ();

  rca_operand_stager #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model_sum(input logic [W-1:0] a, input logic [W-1:0] b);
    longint unsigned s;
    s = longint'(a) + longint'(b);
    return s[W:0];
  endfunction

  // Called just after a falling edge; returns right after the accepting rising edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit done;
    done = 1'b0;
    bus.i_valid     = 1'b1;
    bus.i_add_term1 = a;
    bus.i_add_term2 = b;
    for (int i = 0; i < 40 && !done; i++) begin
      #1;
      if (bus.o_ready) begin
        @(posedge clk);
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL send_accept: operand pair got no o_ready within 40 cycles, required accepted");
    end
  endtask

  // Called right after the accepting edge; ends at the falling edge where o_valid is seen.
  task automatic wait_result(output logic [W:0] res, output int lat);
    @(negedge clk);
    bus.i_valid = 1'b0;
    lat = 0;
    while (!bus.o_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = bus.o_result;
    if (!bus.o_valid) begin
      checks++;
      errors++;
      $display("FAIL result_timeout: o_valid=%0b after %0d edges, required 1", bus.o_valid, lat);
    end
  endtask

  task automatic drain();
    bus.i_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_result !== '0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: valid=%b result=%h ready=%b busy=%b, required 0/0/1/0",
               bus.o_valid, bus.o_result, bus.o_ready, bus.o_busy);
    end
  endtask

  task automatic test_single();
    logic [W:0] res;
    int lat;
    bus.i_ready = 1'b1;
    send(27'h7FFFFFF, 27'h0000001);
    wait_result(res, lat);
    checks++;
    if (lat !== SC) begin
      errors++;
      $display("FAIL single_latency: got %0d edges, required %0d", lat, SC);
    end
    checks++;
    if (res !== 28'h8000000) begin
      errors++;
      $display("FAIL single_carry: got %h, required %h", res, 28'h8000000);
    end
    drain();
    send(27'h7FFFFFF, 27'h7FFFFFF);
    wait_result(res, lat);
    checks++;
    if (res !== 28'hFFFFFFE) begin
      errors++;
      $display("FAIL single_max: got %h, required %h", res, 28'hFFFFFFE);
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [W:0] res;
    logic [W:0] exp;
    int lat;
    exp = model_sum(27'h1234567, 27'h0ABCDEF);
    bus.i_ready = 1'b0;
    send(27'h1234567, 27'h0ABCDEF);
    wait_result(res, lat);
    for (int i = 0; i < 5; i++) begin
      bus.i_valid     = 1'b1;
      bus.i_add_term1 = $urandom() & MASK;
      bus.i_add_term2 = $urandom() & MASK;
      #1;
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== exp || bus.o_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure_hold: valid=%b result=%h ready=%b, required 1/%h/0",
                 bus.o_valid, bus.o_result, bus.o_ready, exp);
      end
      @(negedge clk);
    end
    bus.i_valid = 1'b0;
    drain();
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_busy !== 1'b0 || bus.o_ready !== 1'b1) begin
      errors++;
      $display("FAIL backpressure_release: valid=%b busy=%b ready=%b, required 0/0/1",
               bus.o_valid, bus.o_busy, bus.o_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [W:0] res;
    int lat;
    bus.i_ready = 1'b1;
    send(27'd3, 27'd4);
    wait_result(res, lat);
    checks++;
    if (res !== 28'h0000007) begin
      errors++;
      $display("FAIL b2b_first: got %h, required %h", res, 28'h0000007);
    end
    send(27'h1000000, 27'h1000000);
    wait_result(res, lat);
    checks++;
    if (res !== 28'h2000000 || lat !== SC) begin
      errors++;
      $display("FAIL b2b_second: got %h after %0d edges, required %h after %0d",
               res, lat, 28'h2000000, SC);
    end
    drain();
  endtask

  task automatic test_reset_mid_settle();
    bit bad;
    bus.i_ready = 1'b1;
    send(27'd5, 27'd6);
    @(negedge clk);
    bus.i_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.o_result !== '0 || bus.o_ready !== 1'b1 || bus.o_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_settle: valid=%b result=%h ready=%b busy=%b, required 0/0/1/0",
               bus.o_valid, bus.o_result, bus.o_ready, bus.o_busy);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (bus.o_valid !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_discard: o_valid rose after reset, required 0");
    end
  endtask

  task automatic test_isolation();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0] res;
    int lat;
    a = $urandom() & MASK;
    b = $urandom() & MASK;
    bus.i_ready = 1'b0;
    send(a, b);
    for (int i = 0; i < SC + 2; i++) begin
      @(negedge clk);
      bus.i_valid     = 1'b1;
      bus.i_add_term1 = $urandom() & MASK;
      bus.i_add_term2 = $urandom() & MASK;
      #1;
      checks++;
      if (bus.o_ready !== 1'b0) begin
        errors++;
        $display("FAIL isolation_ready: got %b, required 0", bus.o_ready);
      end
    end
    res = bus.o_result;
    checks++;
    if (bus.o_valid !== 1'b1 || res !== model_sum(a, b)) begin
      errors++;
      $display("FAIL isolation_result: valid=%b result=%h, required 1/%h", bus.o_valid, res, model_sum(a, b));
    end
    @(negedge clk);
    bus.i_valid = 1'b0;
    drain();
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0] res;
    int lat;
    int stall;
    int bad;
    bad = 0;
    for (int n = 0; n < 60; n++) begin
      a = (n % 7 == 0) ? MASK : ($urandom() & MASK);
      b = (n % 5 == 0) ? MASK : ($urandom() & MASK);
      bus.i_ready = 1'($urandom_range(0, 1));
      send(a, b);
      wait_result(res, lat);
      checks++;
      if (res !== model_sum(a, b) || lat !== SC) begin
        errors++;
        bad++;
        if (bad < 10)
          $display("FAIL random_sum[%0d]: got %h after %0d edges, required %h after %0d",
                   n, res, lat, model_sum(a, b), SC);
      end
      stall = $urandom_range(0, 3);
      bus.i_ready = 1'b0;
      repeat (stall) @(negedge clk);
      checks++;
      if (bus.o_valid !== 1'b1 || bus.o_result !== model_sum(a, b)) begin
        errors++;
        $display("FAIL random_stall[%0d]: valid=%b result=%h, required 1/%h",
                 n, bus.o_valid, bus.o_result, model_sum(a, b));
      end
      drain();
    end
  endtask

`ifdef RCA_STAGER_SELF_CHECK_EN
  task automatic test_self_check();
    logic [W:0] res;
    int lat;
    bus.i_ready = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      send($urandom() & MASK, $urandom() & MASK);
      wait_result(res, lat);
      drain();
    end
    checks++;
    if (bus.o_check_err !== 1'b0) begin
      errors++;
      $display("FAIL selfcheck_clean: got %b, required 0", bus.o_check_err);
    end
    force dut.sum_w = 28'd1;
    send(27'd0, 27'd0);
    wait_result(res, lat);
    release dut.sum_w;
    drain();
    send(27'd9, 27'd9);
    wait_result(res, lat);
    drain();
    checks++;
    if (bus.o_check_err !== 1'b1) begin
      errors++;
      $display("FAIL selfcheck_sticky: got %b, required 1", bus.o_check_err);
    end
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (bus.o_check_err !== 1'b0) begin
      errors++;
      $display("FAIL selfcheck_reset: got %b, required 0", bus.o_check_err);
    end
  endtask
`endif

  initial begin
    checks          = 0;
    errors          = 0;
    rst_n           = 1'b0;
    bus.i_valid     = 1'b0;
    bus.i_ready     = 1'b0;
    bus.i_add_term1 = '0;
    bus.i_add_term2 = '0;
    @(negedge clk);
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_settle();
    test_isolation();
    test_random();
`ifdef RCA_STAGER_SELF_CHECK_EN
    test_self_check();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
